mips_mc_ctrl: RTL and testbench

- Multi-cycle control unit for the badmips datapath.
- Sits directly upstream of the ALU: latches each instruction, sequences FETCH/DECODE/EXEC/MEM/WB, and drives ALU_OP, operand selects and all datapath write enables.
- Consumes the ALU's ZF for branches and OF for a sticky overflow status.
- Handshakes with a single instruction/data memory port.

---
 rtl/mips_pkg.sv | 79 +++++++
 rtl/mips_mc_decode.sv | 75 +++++++
 rtl/mips_mc_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mips_pkg                                                    |
// | Purpose  : Shared encodings for the badmips multi-cycle control unit:  |
// |            FSM states, instruction classes, ALU operation codes,       |
// |            opcode/funct values and datapath select codes.              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package mips_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE  = 3'd0,
      CLS_IALU   = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JUMP   = 3'd5
   } iclass_t;

   // ALU operation codes
   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_NOR = 3'd3;
   localparam logic [2:0] ALU_ADD = 3'd4;
   localparam logic [2:0] ALU_SUB = 3'd5;
   localparam logic [2:0] ALU_SLT = 3'd6;
   localparam logic [2:0] ALU_SLL = 3'd7;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operand A select
   localparam logic [1:0] SRCA_RS    = 2'd0;
   localparam logic [1:0] SRCA_PC    = 2'd1;
   localparam logic [1:0] SRCA_SHAMT = 2'd2;

   // ALU operand B select
   localparam logic [2:0] SRCB_RT       = 3'd0;
   localparam logic [2:0] SRCB_FOUR     = 3'd1;
   localparam logic [2:0] SRCB_SEXT     = 3'd2;
   localparam logic [2:0] SRCB_ZEXT     = 3'd3;
   localparam logic [2:0] SRCB_SEXT_SH2 = 3'd4;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mips_mc_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mips_mc_decode                                              |
// | Purpose  : Combinational instruction classifier. Maps the latched      |
// |            opcode/funct to an instruction class, the ALU operation     |
// |            used in EXEC, the immediate-extend select and a legal flag. |
// | Ports    : opcode, funct  in   IR[31:26], IR[5:0]                      |
// |            iclass        out  instruction class                       |
// |            alu_op        out  EXEC ALU operation                       |
// |            zext          out  1 = zero-extend immediate                |
// |            legal         out  1 = supported instruction                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mips_mc_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output logic [2:0] alu_op,
   output logic       zext,
   output logic       legal
);

   always_comb begin
      iclass = CLS_RTYPE;
      alu_op = ALU_ADD;
      zext   = 1'b0;
      legal  = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_XOR:  alu_op = ALU_XOR;
               FN_NOR:  alu_op = ALU_NOR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLL:  alu_op = ALU_SLL;
               default: legal  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            iclass = CLS_IALU;
            alu_op = ALU_ADD;
         end
         OP_ANDI: begin
            iclass = CLS_IALU;
            alu_op = ALU_AND;
            zext   = 1'b1;
         end
         OP_ORI: begin
            iclass = CLS_IALU;
            alu_op = ALU_OR;
            zext   = 1'b1;
         end
         OP_XORI: begin
            iclass = CLS_IALU;
            alu_op = ALU_XOR;
            zext   = 1'b1;
         end
         OP_LW:   iclass = CLS_LOAD;
         OP_SW:   iclass = CLS_STORE;
         OP_BEQ, OP_BNE: begin
            iclass = CLS_BRANCH;
            alu_op = ALU_SUB;
         end
         OP_J:    iclass = CLS_JUMP;
         default: legal  = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mips_mc_ctrl                                                |
// | Purpose  : Multi-cycle control unit for the badmips datapath.          |
// |            Sequences FETCH/DECODE/EXEC/MEM/WB, latches the            |
// |            instruction, drives ALU controls, operand selects and all   |
// |            datapath write enables, and watches the memory handshake.   |
// | Ports    : clk, rst_n            clock / async active-low reset        |
// |            instr, mem_rdy        memory read data / completion         |
// |            zf, of                ALU zero / overflow flags             |
// |            mem_req/we/src        memory request, store, address sel   |
// |            ir/pc/rf/aluout_we    register write enables                |
// |            alu_op, alu_src_a/b   ALU operation and operand selects     |
// |            pc_src, reg_dst       next-PC and destination selects       |
// |            mem_to_reg            write-back source                     |
// |            rs..target            fields of the latched IR              |
// |            illegal, ovf, bus_err status                                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_rdy,
   input  logic        zf,
   input  logic        of,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_src,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic        aluout_we,
   output logic [2:0]  alu_op,
   output logic [1:0]  alu_src_a,
   output logic [2:0]  alu_src_b,
   output logic [1:0]  pc_src,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm,
   output logic [25:0] target,
   output logic        illegal,
   output logic        ovf,
   output logic        bus_err
);

   // Wait counter only ever reaches MEM_TIMEOUT-1 before the state changes.
   localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t          state;
   state_t          next_state;
   logic [31:0]     ir;
   logic [WD_W-1:0] wait_cnt;
   logic            of_cap;
   logic            waiting;
   logic            wd_expire;
   logic            ovf_capable;

   iclass_t         iclass;
   logic [2:0]      dec_op;
   logic            zext;
   logic            legal;
   logic [5:0]      opcode;

   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign shamt  = ir[10:6];
   assign imm    = ir[15:0];
   assign target = ir[25:0];

   mips_mc_decode u_decode (
      .opcode (opcode),
      .funct  (ir[5:0]),
      .iclass (iclass),
      .alu_op (dec_op),
      .zext   (zext),
      .legal  (legal)
   );

   // Only add, sub and addi report overflow.
   assign ovf_capable = legal &&
                        (((iclass == CLS_RTYPE) && ((dec_op == ALU_ADD) || (dec_op == ALU_SUB))) ||
                         ((iclass == CLS_IALU) && (dec_op == ALU_ADD)));

   assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_rdy;

   generate
      if (MEM_TIMEOUT > 0) begin : g_watchdog
         assign wd_expire = waiting && (wait_cnt == WD_W'(MEM_TIMEOUT - 1));
      end else begin : g_no_watchdog
         assign wd_expire = 1'b0;
      end
   endgenerate

   always_comb begin
      next_state = state;
      case (state)
         ST_FETCH: begin
            if (mem_rdy)        next_state = ST_DECODE;
            else if (wd_expire) next_state = ST_HALT;
         end
         ST_DECODE: begin
            if (!legal || (iclass == CLS_JUMP)) next_state = ST_FETCH;
            else                                next_state = ST_EXEC;
         end
         ST_EXEC: begin
            case (iclass)
               CLS_LOAD, CLS_STORE: next_state = ST_MEM;
               CLS_BRANCH:          next_state = ST_FETCH;
               default:             next_state = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (mem_rdy)        next_state = (iclass == CLS_LOAD) ? ST_WB : ST_FETCH;
            else if (wd_expire) next_state = ST_HALT;
         end
         ST_WB:   next_state = ST_FETCH;
         ST_HALT: next_state = ST_HALT;
         default: next_state = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_FETCH;
         ir       <= '0;
         wait_cnt <= '0;
         of_cap   <= 1'b0;
         ovf      <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         state <= next_state;

         if ((state == ST_FETCH) && mem_rdy)
            ir <= instr;

         if (mem_rdy || (next_state != state))
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + 1'b1;

         // OF belongs to the EXEC result; it is folded into OVF at write-back.
         if (state == ST_EXEC)
            of_cap <= of && ovf_capable;

         if ((state == ST_WB) && of_cap)
            ovf <= 1'b1;

         if (wd_expire)
            bus_err <= 1'b1;
      end
   end

   // Control outputs decode from state and IR; mem_rdy and zf qualify the
   // enables that complete in the same cycle. Everything is forced low while
   // reset is asserted so an aborted instruction issues no writes.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_src    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      aluout_we  = 1'b0;
      alu_op     = ALU_AND;
      alu_src_a  = SRCA_RS;
      alu_src_b  = SRCB_RT;
      pc_src     = PCSRC_ALU;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      if (rst_n) begin
         case (state)
            ST_FETCH: begin
               mem_req   = 1'b1;
               alu_src_a = SRCA_PC;
               alu_src_b = SRCB_FOUR;
               alu_op    = ALU_ADD;
               if (mem_rdy) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            ST_DECODE: begin
               // Branch target is computed speculatively for every instruction.
               alu_src_a = SRCA_PC;
               alu_src_b = SRCB_SEXT_SH2;
               alu_op    = ALU_ADD;
               if (!legal) begin
                  illegal = 1'b1;
               end else begin
                  aluout_we = 1'b1;
                  if (iclass == CLS_JUMP) begin
                     pc_we  = 1'b1;
                     pc_src = PCSRC_JUMP;
                  end
               end
            end
            ST_EXEC: begin
               case (iclass)
                  CLS_RTYPE: begin
                     alu_src_a = (dec_op == ALU_SLL) ? SRCA_SHAMT : SRCA_RS;
                     alu_src_b = SRCB_RT;
                     alu_op    = dec_op;
                     aluout_we = 1'b1;
                  end
                  CLS_IALU: begin
                     alu_src_b = zext ? SRCB_ZEXT : SRCB_SEXT;
                     alu_op    = dec_op;
                     aluout_we = 1'b1;
                  end
                  CLS_LOAD, CLS_STORE: begin
                     alu_src_b = SRCB_SEXT;
                     alu_op    = ALU_ADD;
                     aluout_we = 1'b1;
                  end
                  CLS_BRANCH: begin
                     alu_op = ALU_SUB;
                     pc_src = PCSRC_ALUOUT;
                     pc_we  = (opcode == OP_BNE) ? !zf : zf;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               // The datapath captures its memory data register on the
               // completing edge of a load; no separate enable is issued.
               mem_req = 1'b1;
               mem_src = 1'b1;
               mem_we  = (iclass == CLS_STORE);
            end
            ST_WB: begin
               rf_we      = 1'b1;
               reg_dst    = (iclass == CLS_RTYPE);
               mem_to_reg = (iclass == CLS_LOAD);
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mips_mc_ctrl                                             |
// | Purpose  : Self-checking bench for mips_mc_ctrl. Per-cycle expected    |
// |            control vectors are queued as stimulus is applied and       |
// |            popped against the DUT outputs on the falling edge.         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_mips_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        mem_rdy, zf, of;
   logic        mem_req, mem_we, mem_src, ir_we, pc_we, rf_we, aluout_we;
   logic [2:0]  alu_op;
   logic [1:0]  alu_src_a;
   logic [2:0]  alu_src_b;
   logic [1:0]  pc_src;
   logic        reg_dst, mem_to_reg;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] target;
   logic        illegal, ovf, bus_err;

   mips_mc_ctrl #(.MEM_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_rdy(mem_rdy), .zf(zf), .of(of),
      .mem_req(mem_req), .mem_we(mem_we), .mem_src(mem_src), .ir_we(ir_we),
      .pc_we(pc_we), .rf_we(rf_we), .aluout_we(aluout_we), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .imm(imm), .target(target), .illegal(illegal), .ovf(ovf),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // {req,we,src,ir_we,pc_we,rf_we,aluout_we,op[3],a[2],b[3],pc_src[2],reg_dst,mem_to_reg,illegal}
   logic [19:0] ctl;
   assign ctl = {mem_req, mem_we, mem_src, ir_we, pc_we, rf_we, aluout_we, alu_op,
                 alu_src_a, alu_src_b, pc_src, reg_dst, mem_to_reg, illegal};

   localparam logic [19:0] V_FW    = {7'b1000000, 3'd4, 2'd1, 3'd1, 2'd0, 3'b000};
   localparam logic [19:0] V_FR    = {7'b1001100, 3'd4, 2'd1, 3'd1, 2'd0, 3'b000};
   localparam logic [19:0] V_DEC   = {7'b0000001, 3'd4, 2'd1, 3'd4, 2'd0, 3'b000};
   localparam logic [19:0] V_DJ    = {7'b0000101, 3'd4, 2'd1, 3'd4, 2'd2, 3'b000};
   localparam logic [19:0] V_DILL  = {7'b0000000, 3'd4, 2'd1, 3'd4, 2'd0, 3'b001};
   localparam logic [19:0] V_EADD  = {7'b0000001, 3'd4, 2'd0, 3'd0, 2'd0, 3'b000};
   localparam logic [19:0] V_ESLL  = {7'b0000001, 3'd7, 2'd2, 3'd0, 2'd0, 3'b000};
   localparam logic [19:0] V_EORI  = {7'b0000001, 3'd1, 2'd0, 3'd3, 2'd0, 3'b000};
   localparam logic [19:0] V_EADDI = {7'b0000001, 3'd4, 2'd0, 3'd2, 2'd0, 3'b000};
   localparam logic [19:0] V_EMEM  = {7'b0000001, 3'd4, 2'd0, 3'd2, 2'd0, 3'b000};
   localparam logic [19:0] V_EBT   = {7'b0000100, 3'd5, 2'd0, 3'd0, 2'd1, 3'b000};
   localparam logic [19:0] V_EBN   = {7'b0000000, 3'd5, 2'd0, 3'd0, 2'd1, 3'b000};
   localparam logic [19:0] V_MLW   = {7'b1010000, 3'd0, 2'd0, 3'd0, 2'd0, 3'b000};
   localparam logic [19:0] V_MSW   = {7'b1110000, 3'd0, 2'd0, 3'd0, 2'd0, 3'b000};
   localparam logic [19:0] V_WR    = {7'b0000010, 3'd0, 2'd0, 3'd0, 2'd0, 3'b100};
   localparam logic [19:0] V_WI    = {7'b0000010, 3'd0, 2'd0, 3'd0, 2'd0, 3'b000};
   localparam logic [19:0] V_WLW   = {7'b0000010, 3'd0, 2'd0, 3'd0, 2'd0, 3'b010};

   typedef struct packed {
      logic        rdy;
      logic        zf;
      logic        of;
      logic        eovf;
      logic [31:0] instr;
      logic [19:0] exp;
   } cyc_t;

   logic [19:0] expq[$];
   int checks = 0;
   int passes = 0;

   function automatic cyc_t cy(input logic r, input logic z, input logic o, input logic eo,
                               input logic [31:0] ins, input logic [19:0] e);
      cyc_t c;
      c.rdy = r; c.zf = z; c.of = o; c.eovf = eo; c.instr = ins; c.exp = e;
      return c;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; mem_rdy = 1'b0; zf = 1'b0; of = 1'b0; instr = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ctl !== 20'h0) $display("FAIL reset_ctl got=%05h want=00000", ctl); else passes++;
      checks++;
      if ({ovf, bus_err} !== 2'b00) $display("FAIL reset_status got=%b want=00", {ovf, bus_err}); else passes++;
      checks++;
      if ({rs, rt, rd, shamt, imm, target} !== 62'h0) $display("FAIL reset_ir got=%h want=0", {rs, rt, rd, shamt, imm, target}); else passes++;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      cyc_t s[$];
      logic [19:0] want;
      s.push_back(cy(1, 0, 0, 0, 32'h00221820, V_FR));
      s.push_back(cy(1, 0, 0, 0, 32'h00221820, V_DEC));
      s.push_back(cy(1, 0, 0, 0, 32'h00221820, V_EADD));
      s.push_back(cy(1, 0, 0, 0, 32'h00221820, V_WR));
      foreach (s[i]) begin
         instr = s[i].instr; mem_rdy = s[i].rdy; zf = s[i].zf; of = s[i].of;
         expq.push_back(s[i].exp);
         @(negedge clk);
         want = expq.pop_front();
         checks++;
         if (ctl !== want) $display("FAIL add_ctl cyc%0d got=%05h want=%05h", i, ctl, want); else passes++;
         checks++;
         if (ovf !== s[i].eovf) $display("FAIL add_ovf cyc%0d got=%b want=%b", i, ovf, s[i].eovf); else passes++;
         @(posedge clk); #1;
      end
      checks++;
      if ({rs, rt, rd} !== {5'd1, 5'd2, 5'd3}) $display("FAIL add_fields got=%h want=%h", {rs, rt, rd}, {5'd1, 5'd2, 5'd3}); else passes++;
   endtask

   // ori (OF ignored), addi (OF sets OVF), j - issued without gaps
   task automatic test_back_to_back();
      cyc_t s[$];
      logic [19:0] want;
      s.push_back(cy(1, 0, 0, 0, 32'h34220005, V_FR));
      s.push_back(cy(1, 0, 0, 0, 32'h34220005, V_DEC));
      s.push_back(cy(1, 0, 1, 0, 32'h34220005, V_EORI));
      s.push_back(cy(1, 0, 0, 0, 32'h34220005, V_WI));
      s.push_back(cy(1, 0, 0, 0, 32'h2021FFFF, V_FR));
      s.push_back(cy(1, 0, 0, 0, 32'h2021FFFF, V_DEC));
      s.push_back(cy(1, 0, 1, 0, 32'h2021FFFF, V_EADDI));
      s.push_back(cy(1, 0, 0, 0, 32'h2021FFFF, V_WI));
      s.push_back(cy(1, 0, 0, 1, 32'h08000010, V_FR));
      s.push_back(cy(1, 0, 0, 1, 32'h08000010, V_DJ));
      foreach (s[i]) begin
         instr = s[i].instr; mem_rdy = s[i].rdy; zf = s[i].zf; of = s[i].of;
         expq.push_back(s[i].exp);
         @(negedge clk);
         want = expq.pop_front();
         checks++;
         if (ctl !== want) $display("FAIL b2b_ctl cyc%0d got=%05h want=%05h", i, ctl, want); else passes++;
         checks++;
         if (ovf !== s[i].eovf) $display("FAIL b2b_ovf cyc%0d got=%b want=%b", i, ovf, s[i].eovf); else passes++;
         @(posedge clk); #1;
      end
      checks++;
      if (target !== 26'h10) $display("FAIL j_target got=%h want=0000010", target); else passes++;
   endtask

   task automatic test_lw_wait();
      cyc_t s[$];
      logic [19:0] want;
      s.push_back(cy(1, 0, 0, 1, 32'h8C250008, V_FR));
      s.push_back(cy(1, 0, 0, 1, 32'h8C250008, V_DEC));
      s.push_back(cy(1, 0, 0, 1, 32'h8C250008, V_EMEM));
      s.push_back(cy(0, 0, 0, 1, 32'h8C250008, V_MLW));
      s.push_back(cy(0, 0, 0, 1, 32'h8C250008, V_MLW));
      s.push_back(cy(0, 0, 0, 1, 32'h8C250008, V_MLW));
      s.push_back(cy(1, 0, 0, 1, 32'h8C250008, V_MLW));
      s.push_back(cy(1, 0, 0, 1, 32'h8C250008, V_WLW));
      foreach (s[i]) begin
         instr = s[i].instr; mem_rdy = s[i].rdy; zf = s[i].zf; of = s[i].of;
         expq.push_back(s[i].exp);
         @(negedge clk);
         want = expq.pop_front();
         checks++;
         if (ctl !== want) $display("FAIL lw_ctl cyc%0d got=%05h want=%05h", i, ctl, want); else passes++;
         @(posedge clk); #1;
      end
      checks++;
      if ({rt, imm} !== {5'd5, 16'd8}) $display("FAIL lw_fields got=%h want=%h", {rt, imm}, {5'd5, 16'd8}); else passes++;
   endtask

   task automatic test_branch();
      cyc_t s[$];
      logic [19:0] want;
      s.push_back(cy(1, 1, 0, 1, 32'h10220004, V_FR));
      s.push_back(cy(1, 1, 0, 1, 32'h10220004, V_DEC));
      s.push_back(cy(1, 1, 0, 1, 32'h10220004, V_EBT));
      s.push_back(cy(1, 0, 0, 1, 32'h10220004, V_FR));
      s.push_back(cy(1, 0, 0, 1, 32'h10220004, V_DEC));
      s.push_back(cy(1, 0, 0, 1, 32'h10220004, V_EBN));
      foreach (s[i]) begin
         instr = s[i].instr; mem_rdy = s[i].rdy; zf = s[i].zf; of = s[i].of;
         expq.push_back(s[i].exp);
         @(negedge clk);
         want = expq.pop_front();
         checks++;
         if (ctl !== want) $display("FAIL beq_ctl cyc%0d got=%05h want=%05h", i, ctl, want); else passes++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sll();
      cyc_t s[$];
      logic [19:0] want;
      s.push_back(cy(1, 0, 0, 1, 32'h000220C0, V_FR));
      s.push_back(cy(1, 0, 0, 1, 32'h000220C0, V_DEC));
      s.push_back(cy(1, 0, 0, 1, 32'h000220C0, V_ESLL));
      s.push_back(cy(1, 0, 0, 1, 32'h000220C0, V_WR));
      foreach (s[i]) begin
         instr = s[i].instr; mem_rdy = s[i].rdy; zf = s[i].zf; of = s[i].of;
         expq.push_back(s[i].exp);
         @(negedge clk);
         want = expq.pop_front();
         checks++;
         if (ctl !== want) $display("FAIL sll_ctl cyc%0d got=%05h want=%05h", i, ctl, want); else passes++;
         @(posedge clk); #1;
      end
      checks++;
      if ({rd, shamt} !== {5'd4, 5'd3}) $display("FAIL sll_fields got=%h want=%h", {rd, shamt}, {5'd4, 5'd3}); else passes++;
   endtask

   task automatic test_illegal();
      cyc_t s[$];
      logic [19:0] want;
      s.push_back(cy(1, 0, 0, 1, 32'hFC000000, V_FR));
      s.push_back(cy(1, 0, 0, 1, 32'hFC000000, V_DILL));
      s.push_back(cy(0, 0, 0, 1, 32'hFC000000, V_FW));
      foreach (s[i]) begin
         instr = s[i].instr; mem_rdy = s[i].rdy; zf = s[i].zf; of = s[i].of;
         expq.push_back(s[i].exp);
         @(negedge clk);
         want = expq.pop_front();
         checks++;
         if (ctl !== want) $display("FAIL ill_ctl cyc%0d got=%05h want=%05h", i, ctl, want); else passes++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw_reset();
      cyc_t s[$];
      logic [19:0] want;
      s.push_back(cy(1, 0, 0, 1, 32'hAC250008, V_FR));
      s.push_back(cy(1, 0, 0, 1, 32'hAC250008, V_DEC));
      s.push_back(cy(1, 0, 0, 1, 32'hAC250008, V_EMEM));
      s.push_back(cy(0, 0, 0, 1, 32'hAC250008, V_MSW));
      foreach (s[i]) begin
         instr = s[i].instr; mem_rdy = s[i].rdy; zf = s[i].zf; of = s[i].of;
         expq.push_back(s[i].exp);
         @(negedge clk);
         want = expq.pop_front();
         checks++;
         if (ctl !== want) $display("FAIL sw_ctl cyc%0d got=%05h want=%05h", i, ctl, want); else passes++;
         @(posedge clk); #1;
      end
      // still in MEM; reset aborts the store
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctl !== 20'h0) $display("FAIL swrst_ctl got=%05h want=00000", ctl); else passes++;
      checks++;
      if ({ovf, bus_err} !== 2'b00) $display("FAIL swrst_status got=%b want=00", {ovf, bus_err}); else passes++;
      @(posedge clk); #1;
      rst_n = 1'b1; mem_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (ctl !== V_FW) $display("FAIL swrst_fetch got=%05h want=%05h", ctl, V_FW); else passes++;
      checks++;
      if ({rs, rt, imm} !== 26'h0) $display("FAIL swrst_ir got=%h want=0", {rs, rt, imm}); else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_watchdog();
      int n;
      rst_n = 1'b0; mem_rdy = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      while (bus_err !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n !== 16) $display("FAIL wd_cycles got=%0d want=16", n); else passes++;
      mem_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({ctl, bus_err} !== {20'h0, 1'b1}) $display("FAIL halt_hold cyc%0d got=%05h/%b want=00000/1", k, ctl, bus_err); else passes++;
      end
      @(posedge clk); #1;
      rst_n = 1'b0; mem_rdy = 1'b0;
      #1;
      checks++;
      if (bus_err !== 1'b0) $display("FAIL halt_rst_buserr got=%b want=0", bus_err); else passes++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ctl !== V_FW) $display("FAIL halt_rst_fetch got=%05h want=%05h", ctl, V_FW); else passes++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_lw_wait();
      test_branch();
      test_sll();
      test_illegal();
      test_sw_reset();
      test_watchdog();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
